seq_det_1011: RTL
=================

SEQ_DET_1011 -- requirements
Module: seq_det_1011

Interface
REQ-001 SHALL have parameter CNT_W, default 8, meaning the width of the match counter.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port n_rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port din, input, 1 bit: serial data bit, driven directly by the upstream d_ff q.
REQ-005 SHALL have port en, input, 1 bit: din is sampled only on edges where en=1.
REQ-006 SHALL have port clr, input, 1 bit: synchronous clear of FSM and counter.
REQ-007 SHALL have port match, output, 1 bit: registered one-cycle pulse on detection of 1011.
REQ-008 SHALL have port state_o, output, 3 bits: current FSM state encoding.
REQ-009 SHALL have port match_cnt, output, CNT_W bits: number of matches; present only with SEQ_DET_CNT_EN.

Function
REQ-010 SHALL implement a Moore FSM with states S_IDLE=0, S_1=1, S_10=2, S_101=3, S_1011=4, encoded on state_o.
REQ-011 SHALL use these transitions when en=1 (din=0 / din=1): S_IDLE->S_IDLE/S_1; S_1->S_10/S_1; S_10->S_IDLE/S_101; S_101->S_10/S_1011; S_1011->S_10/S_1.
REQ-012 SHALL detect overlapping occurrences, so 1011011 yields two matches.
REQ-013 SHALL hold the state unchanged on edges with en=0.
REQ-014 SHALL register match <= en & din & (state==S_101), giving match high for exactly the one cycle after the edge that samples the final 1.
REQ-015 SHALL drive match low on any edge with en=0, even when the state holds at S_1011.
REQ-016 SHALL, when clr=1 at an edge, force the state to S_IDLE, match to 0 and match_cnt to 0, regardless of en and din.
REQ-017 SHALL increment match_cnt by 1 on each edge where match is being set, and saturate at 2^CNT_W-1 with no wrap.
REQ-018 SHALL treat states 5-7 as illegal and move from any of them to S_IDLE on the next edge.

Reset
REQ-019 SHALL, while n_rst=0, asynchronously force the state to S_IDLE, match to 0 and match_cnt to 0.
REQ-020 SHALL, when reset is asserted mid-pattern, discard the partial match, so detection restarts from S_IDLE.
REQ-021 SHALL resume sampling on the first rising edge after n_rst deasserts.

Configuration
REQ-022 SHALL, when macro SEQ_DET_CNT_EN is defined, include the match_cnt port and the saturating counter.
REQ-023 SHALL, when SEQ_DET_CNT_EN is undefined, omit both the match_cnt port and the counter logic, and leave match/state_o behaviour otherwise identical.

Structure
REQ-024 SHALL take its state encodings (S_IDLE..S_1011) and the state width constant (3) from the shared package seq_det_pkg.
REQ-025 SHALL instantiate exactly one sub-module, seq_det_cnt, a saturating counter with clk, n_rst, clr and inc inputs and a count output, generated only under SEQ_DET_CNT_EN.
REQ-026 SHALL keep the FSM next-state logic combinational and all outputs registered, with no latches.

Verification
REQ-027 SHALL cover: reset then en=1 with din=1,0,1,1 -> match=1 for one cycle after the 4th edge; state_o=4; match_cnt=1.
REQ-028 SHALL cover: din=1,0,1,1,0,1,1 with en=1 -> two match pulses, 3 cycles apart; match_cnt=2.
REQ-029 SHALL cover: din=1,0 then en=0 for 3 cycles with din toggling, then en=1 and din=1,1 -> state_o holds at 2 during the stall; one match; match_cnt=1.
REQ-030 SHALL cover: din=1,0,1 then clr=1 with din=1 -> state_o=0, match=0, match_cnt=0; no match fires.
REQ-031 SHALL cover: n_rst pulsed low mid-cycle after din=1,0,1 -> outputs zero immediately; the following din=1 gives state_o=1, not a match.
REQ-032 SHALL cover: CNT_W=2 with 5 matches -> match_cnt saturates at 3; with SEQ_DET_CNT_EN undefined, the same stimulus compiles and gives 5 match pulses.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants for the 1011 serial pattern detector: state width and encodings.
package seq_det_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] S_IDLE = 3'd0;
    localparam logic [STATE_W-1:0] S_1    = 3'd1;
    localparam logic [STATE_W-1:0] S_10   = 3'd2;
    localparam logic [STATE_W-1:0] S_101  = 3'd3;
    localparam logic [STATE_W-1:0] S_1011 = 3'd4;

endpackage

// File: rtl/seq_det_cnt.sv
// Saturating match counter; holds at all-ones instead of wrapping.
module seq_det_cnt
    import seq_det_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/seq_det_1011.sv
// Overlapping 1011 detector (Moore FSM) with registered match pulse.
// Optional saturating match counter is built only when SEQ_DET_CNT_EN is defined.
//
//   state  | meaning
//   S_IDLE | no useful prefix seen
//   S_1    | last sampled bits end in 1
//   S_10   | last sampled bits end in 10
//   S_101  | last sampled bits end in 101
//   S_1011 | full pattern just sampled
module seq_det_1011
    import seq_det_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               din,
    input  logic               en,
    input  logic               clr,
    output logic               match,
    output logic [STATE_W-1:0] state_o
`ifdef SEQ_DET_CNT_EN
    ,
    output logic [CNT_W-1:0]   match_cnt
`endif
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("seq_det_1011: CNT_W must be at least 1");
    end

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic               hit;

    assign hit = en & din & (state == S_101);

    // Illegal encodings recover to idle even while sampling is stalled.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (en) state_nxt = din ? S_1    : S_IDLE;
            S_1:     if (en) state_nxt = din ? S_1    : S_10;
            S_10:    if (en) state_nxt = din ? S_101  : S_IDLE;
            S_101:   if (en) state_nxt = din ? S_1011 : S_10;
            S_1011:  if (en) state_nxt = din ? S_1    : S_10;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= S_IDLE;
            match <= 1'b0;
        end else if (clr) begin
            state <= S_IDLE;
            match <= 1'b0;
        end else begin
            state <= state_nxt;
            match <= hit;
        end
    end

    assign state_o = state;

`ifdef SEQ_DET_CNT_EN
    seq_det_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (clr),
        .inc   (hit),
        .count (match_cnt)
    );
`endif

endmodule
